// File: rtl/bsg_transpose_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_transpose_stream_pkg
//  Purpose  : Shared helpers for the streaming transposer (counter sizing).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bsg_transpose_stream_pkg;

    // Width of a counter that spans 0..n-1. It never drops below one bit,
    // so that a dimension of 1 still yields a legal (constant-zero) counter.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_transpose_stream_bank.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_transpose_stream_bank
//  Purpose  : One els_p x width_p element store. A full row is written per
//             cycle and a full column is read combinationally.
//  Ports    : clk_i   - clock
//             we_i    - row write enable
//             row_i   - row index being written
//             data_i  - row data, element y at [y*type_width_p +: type_width_p]
//             col_i   - column index being read
//             data_o  - column data, element x = row x of the selected column
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_transpose_stream_bank
    import bsg_transpose_stream_pkg::*;
#(
    parameter int width_p      = 1,
    parameter int els_p        = 1,
    parameter int type_width_p = 1,
    localparam int c_ROW_W     = safe_clog2(els_p),
    localparam int c_COL_W     = safe_clog2(width_p)
) (
    input  logic                            clk_i,
    input  logic                            we_i,
    input  logic [c_ROW_W-1:0]              row_i,
    input  logic [width_p*type_width_p-1:0] data_i,
    input  logic [c_COL_W-1:0]              col_i,
    output logic [els_p*type_width_p-1:0]   data_o
);

    // Storage carries no reset: the full flags in the parent decide when
    // its contents are meaningful.
    logic [width_p*type_width_p-1:0] r_mem [els_p];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[row_i] <= data_i;
        end
    end

    // Column read: element x of the output is element col_i of row x.
    for (genvar x = 0; x < els_p; x++) begin : g_col
        assign data_o[x*type_width_p +: type_width_p] =
            r_mem[x][col_i*type_width_p +: type_width_p];
    end

endmodule
`default_nettype wire

// File: rtl/bsg_transpose_stream.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_transpose_stream
//  Purpose  : Streaming ready/valid matrix transposer. Takes els_p rows of
//             width_p elements (one row per beat) and emits width_p columns
//             of els_p elements (one column per beat). Optional ping-pong
//             banking lets a fill and a drain proceed concurrently.
//  Ports    : clk_i       - clock
//             reset_n_i   - synchronous active-low reset
//             v_i         - input row valid
//             data_i      - input row
//             ready_and_o - input row accepted when v_i & ready_and_o
//             v_o         - output column valid
//             data_o      - output column
//             ready_and_i - output column consumed when v_o & ready_and_i
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_transpose_stream
    import bsg_transpose_stream_pkg::*;
#(
    parameter int width_p         = 1,   // elements per input row
    parameter int els_p           = 1,   // rows per matrix
    parameter int type_width_p    = 1,
    parameter int double_buffer_p = 1
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            v_i,
    input  logic [width_p*type_width_p-1:0] data_i,
    output logic                            ready_and_o,
    output logic                            v_o,
    output logic [els_p*type_width_p-1:0]   data_o,
    input  logic                            ready_and_i
);

    localparam int c_NB    = (double_buffer_p != 0) ? 2 : 1;
    localparam int c_ROW_W = safe_clog2(els_p);
    localparam int c_COL_W = safe_clog2(width_p);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(els_p - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(width_p - 1);

    logic [c_ROW_W-1:0] r_wr_row;
    logic [c_COL_W-1:0] r_rd_col;
    logic               r_wr_bank;
    logic               r_rd_bank;
    // Always two flag bits; in single-bank mode the pointers stay at 0 and
    // bit 1 is never set.
    logic [1:0]         r_full;

    logic               w_accept;
    logic               w_consume;
    logic [c_NB-1:0]    w_we;
    logic [els_p*type_width_p-1:0] w_bank_data [2];

    assign ready_and_o = reset_n_i & ~r_full[r_wr_bank];
    assign v_o         = r_full[r_rd_bank];
    assign w_accept    = v_i & ready_and_o;
    assign w_consume   = v_o & ready_and_i;

    for (genvar b = 0; b < c_NB; b++) begin : g_bank
        assign w_we[b] = w_accept & (r_wr_bank == 1'(b));

        bsg_transpose_stream_bank #(
            .width_p      (width_p),
            .els_p        (els_p),
            .type_width_p (type_width_p)
        ) u_bank (
            .clk_i  (clk_i),
            .we_i   (w_we[b]),
            .row_i  (r_wr_row),
            .data_i (data_i),
            .col_i  (r_rd_col),
            .data_o (w_bank_data[b])
        );
    end

    // Single-bank mode: alias the second mux input so the output select
    // stays uniform.
    if (c_NB == 1) begin : g_single
        assign w_bank_data[1] = w_bank_data[0];
    end

    assign data_o = w_bank_data[r_rd_bank];

    // Accept only targets an empty bank and consume only a full one, so the
    // two flag updates below always land on different bits.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wr_row  <= '0;
            r_rd_col  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_full    <= 2'b00;
        end else begin
            if (w_accept) begin
                if (r_wr_row == c_ROW_LAST) begin
                    r_wr_row          <= '0;
                    r_full[r_wr_bank] <= 1'b1;
                    if (c_NB == 2) begin
                        r_wr_bank <= ~r_wr_bank;
                    end
                end else begin
                    r_wr_row <= r_wr_row + 1'b1;
                end
            end
            if (w_consume) begin
                if (r_rd_col == c_COL_LAST) begin
                    r_rd_col          <= '0;
                    r_full[r_rd_bank] <= 1'b0;
                    if (c_NB == 2) begin
                        r_rd_bank <= ~r_rd_bank;
                    end
                end else begin
                    r_rd_col <= r_rd_col + 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!$isunknown(v_i))
                else $error("bsg_transpose_stream: v_i is X/Z");
            assert (!$isunknown(ready_and_i))
                else $error("bsg_transpose_stream: ready_and_i is X/Z");
            assert (!(w_consume && !v_o))
                else $error("bsg_transpose_stream: consume without v_o");
        end
    end
`endif

endmodule
`default_nettype wire
